// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target responder.
// State encoding, bus ACK levels and the byte shift helper live here.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK,
    IGNORE
  } i2c_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // MSB-first shift: the newest bus bit enters at bit 0.
  function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic b);
    return {sr[6:0], b};
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the Clock domain and flags SCL edges plus START/STOP.
// Flops reset to 1 so a quiet bus looks idle straight out of reset.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync[0] <= scl;
      sda_sync[0] <= sda;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_sync[i] <= scl_sync[i-1];
        sda_sync[i] <= sda_sync[i-1];
      end
      scl_d <= scl_sync[SYNC_STAGES-1];
      sda_d <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;

  // Qualify on the previous SCL sample so a START that lands with an SCL
  // fall in the same cycle is still seen as a START.
  assign start_det = scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, pointer write, data writes and auto-incrementing reads
// against an external register port. SCL is never stretched.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS     = 7'h77,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        PW          = $clog2(NUM_REGS)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          SCL,
  input  logic          SDA_In,
  output logic          SDA_Out,
  output logic [PW-1:0] reg_addr,
  input  logic [7:0]    reg_rdata,
  output logic [7:0]    reg_wdata,
  output logic          reg_we,
  output logic          busy,
  output i2c_state_t    dbg_state
);

  // Handshake: reg_we is a single-cycle strobe; reg_wdata and reg_addr are
  // valid while it is high. reg_rdata must follow reg_addr combinationally.

  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic       sda_s;

  i2c_state_t state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] byte_in;
  logic       rw;
  logic       ack_drv;
  logic       sda_out;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .Clock     (Clock),
    .Reset     (Reset),
    .scl       (SCL),
    .sda       (SDA_In),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  assign byte_in   = shift_in(shreg, sda_s);
  assign SDA_Out   = sda_out;
  assign dbg_state = state;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      rw        <= 1'b0;
      ack_drv   <= 1'b0;
      sda_out   <= 1'b1;
      busy      <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      if (start_det) begin
        // A repeated START drops any partial byte; busy is re-evaluated at address match.
        state   <= ADDR;
        bit_cnt <= '0;
        ack_drv <= 1'b0;
        sda_out <= 1'b1;
      end else if (stop_det) begin
        state   <= IDLE;
        bit_cnt <= '0;
        ack_drv <= 1'b0;
        sda_out <= 1'b1;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE, IGNORE: begin
            sda_out <= 1'b1;
          end

          ADDR: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw <= byte_in[0];
                // Address 0 is the general call, which this target does not answer.
                if (byte_in[7:1] == ADDRESS && byte_in[7:1] != 7'd0) begin
                  state <= ADDR_ACK;
                  busy  <= 1'b1;
                end else begin
                  state <= IGNORE;
                  busy  <= 1'b0;
                end
              end
            end
          end

          PTR: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                reg_addr <= byte_in[PW-1:0];
                state    <= PTR_ACK;
              end
            end
          end

          WDATA: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                reg_wdata <= byte_in;
                reg_we    <= 1'b1;
                state     <= WDATA_ACK;
              end
            end
          end

          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            // First fall opens the ACK slot, second fall closes it.
            if (scl_fall) begin
              if (!ack_drv) begin
                ack_drv <= 1'b1;
                sda_out <= I2C_ACK;
              end else begin
                ack_drv <= 1'b0;
                sda_out <= 1'b1;
                bit_cnt <= '0;
                case (state)
                  ADDR_ACK: begin
                    if (rw) begin
                      sda_out <= reg_rdata[7];
                      shreg   <= {reg_rdata[6:0], 1'b0};
                      state   <= RDATA;
                    end else begin
                      state <= PTR;
                    end
                  end
                  PTR_ACK: state <= WDATA;
                  default: begin
                    reg_addr <= reg_addr + PW'(1);
                    state    <= WDATA;
                  end
                endcase
              end
            end
          end

          RDATA: begin
            // MSB was placed on the wire when this byte was loaded.
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_out <= 1'b1;
                bit_cnt <= '0;
                state   <= RACK;
              end else begin
                sda_out <= shreg[7];
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end

          RACK: begin
            if (scl_rise) begin
              if (sda_s == I2C_NACK) begin
                state <= IGNORE;
                busy  <= 1'b0;
              end else begin
                reg_addr <= reg_addr + PW'(1);
              end
            end else if (scl_fall) begin
              sda_out <= reg_rdata[7];
              shreg   <= {reg_rdata[6:0], 1'b0};
              bit_cnt <= '0;
              state   <= RDATA;
            end
          end

          default: begin
            state   <= IDLE;
            sda_out <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bus-master tasks, an array model of the register file,
// and a scoreboard of expected register writes and read bytes.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int NUM_REGS = 16;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       SCL   = 1'b1;
  logic       sda_m = 1'b1;
  logic       SDA_In;
  logic       SDA_Out;
  logic [3:0] reg_addr;
  logic [7:0] reg_rdata;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       busy;
  i2c_state_t dbg_state;

  logic [7:0]  ext_mem[NUM_REGS];
  logic [7:0]  model_mem[NUM_REGS];
  int          model_ptr;
  logic [11:0] exp_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [11:0] mon_e;
  logic        sda_low_seen;
  int          n_checks = 0;
  int          n_fail = 0;

  // Open-drain wire: either side can pull low.
  assign SDA_In    = sda_m & SDA_Out;
  assign reg_rdata = ext_mem[reg_addr];

  i2c_target dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .SCL       (SCL),
    .SDA_In    (SDA_In),
    .SDA_Out   (SDA_Out),
    .reg_addr  (reg_addr),
    .reg_rdata (reg_rdata),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (reg_we) ext_mem[reg_addr] <= reg_wdata;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- write monitor ----------------
  always @(negedge Clock) begin
    if (!Reset && SDA_Out == 1'b0) sda_low_seen = 1'b1;
    if (!Reset && reg_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_reg_we: got addr 0x%0h data 0x%0h, none expected", reg_addr, reg_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("reg_we_addr", 32'(reg_addr), 32'(mon_e[11:8]));
        check("reg_we_data", 32'(reg_wdata), 32'(mon_e[7:0]));
      end
    end
  end

  // ---------------- bus master drivers ----------------
  task automatic bus_bit(input logic b, output logic s);
    wait_clk(6); sda_m = b;
    wait_clk(4); SCL = 1'b1;
    wait_clk(4); s = SDA_In;
    wait_clk(4); SCL = 1'b0;
  endtask

  task automatic bus_start();
    if (SCL == 1'b0) begin
      wait_clk(6); sda_m = 1'b1;
      wait_clk(4); SCL = 1'b1;
      wait_clk(6);
    end
    sda_m = 1'b0;
    wait_clk(6); SCL = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(6); sda_m = 1'b0;
    wait_clk(4); SCL = 1'b1;
    wait_clk(6); sda_m = 1'b1;
    wait_clk(10);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic exp_ack, input string name);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, s);
    check(name, 32'(s), 32'(exp_ack));
  endtask

  task automatic read_byte(input logic master_ack, input string name);
    logic s;
    logic [7:0] got;
    got = '0;
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, s);
      got = {got[6:0], s};
    end
    bus_bit(master_ack, s);
    if (exp_rd_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got 0x%0h with no expected byte queued", name, got);
    end else begin
      check(name, 32'(got), 32'(exp_rd_q.pop_front()));
    end
  endtask

  // ---------------- reference model ----------------
  task automatic set_ptr(input logic [7:0] p);
    send_byte(p, I2C_ACK, "ptr_ack");
    model_ptr = p % NUM_REGS;
  endtask

  task automatic write_data(input logic [7:0] d);
    exp_q.push_back({4'(model_ptr), d});
    model_mem[model_ptr] = d;
    model_ptr = (model_ptr + 1) % NUM_REGS;
    send_byte(d, I2C_ACK, "wdata_ack");
  endtask

  task automatic rd_bytes(input int n);
    bus_start();
    send_byte(8'hEF, I2C_ACK, "addr_r_ack");
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back(model_mem[model_ptr]);
      if (i == n - 1) begin
        read_byte(I2C_NACK, "read_byte");
      end else begin
        read_byte(I2C_ACK, "read_byte");
        model_ptr = (model_ptr + 1) % NUM_REGS;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic s;
    int   kind;
    int   n;
    logic [6:0] a;

    for (int i = 0; i < NUM_REGS; i++) begin
      ext_mem[i]   = 8'(i * 8'h11) ^ 8'h3C;
      model_mem[i] = ext_mem[i];
    end
    ext_mem[4]   = 8'h5A;
    model_mem[4] = 8'h5A;
    model_ptr    = 0;
    sda_low_seen = 1'b0;

    wait_clk(5);
    check("rst_sda_out", 32'(SDA_Out), 32'd1);
    check("rst_reg_we", 32'(reg_we), 32'd0);
    check("rst_reg_wdata", 32'(reg_wdata), 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    Reset = 1'b0;
    wait_clk(10);

    // Write 0xA5 to register 3.
    bus_start();
    send_byte(8'hEE, I2C_ACK, "addr_w_ack");
    check("busy_in_write", 32'(busy), 32'd1);
    set_ptr(8'h03);
    write_data(8'hA5);
    bus_stop();
    check("busy_after_write", 32'(busy), 32'd0);
    check("write_drained", 32'(exp_q.size()), 32'd0);

    // Set pointer 3, repeated START, read two bytes (ACK then NACK).
    bus_start();
    send_byte(8'hEE, I2C_ACK, "addr_w_ack");
    set_ptr(8'h03);
    rd_bytes(2);
    wait_clk(4);
    check("sda_released_after_nack", 32'(SDA_Out), 32'd1);
    check("busy_after_nack", 32'(busy), 32'd0);
    bus_stop();

    // Wrong address: no ACK anywhere, nothing written, not busy.
    sda_low_seen = 1'b0;
    bus_start();
    send_byte(8'hA0, I2C_NACK, "wrong_addr_nack");
    send_byte(8'h55, I2C_NACK, "ignored_byte_nack");
    check("wrong_addr_busy", 32'(busy), 32'd0);
    check("wrong_addr_sda_quiet", 32'(sda_low_seen), 32'd0);
    bus_stop();

    // General call is not answered.
    bus_start();
    send_byte(8'h00, I2C_NACK, "general_call_nack");
    bus_stop();

    // Pointer wrap on the write path.
    bus_start();
    send_byte(8'hEE, I2C_ACK, "addr_w_ack");
    set_ptr(8'h0F);
    write_data(8'h11);
    write_data(8'h22);
    bus_stop();
    check("wrap_drained", 32'(exp_q.size()), 32'd0);

    // Pointer wrap on the read path: 15 then 0.
    bus_start();
    send_byte(8'hEE, I2C_ACK, "addr_w_ack");
    set_ptr(8'hFF);
    rd_bytes(2);
    bus_stop();

    // STOP after 4 data bits: byte discarded.
    bus_start();
    send_byte(8'hEE, I2C_ACK, "addr_w_ack");
    set_ptr(8'h07);
    for (int i = 0; i < 4; i++) bus_bit(1'(i[0]), s);
    bus_stop();
    check("stop_mid_state", 32'(dbg_state), 32'(IDLE));
    check("stop_mid_sda", 32'(SDA_Out), 32'd1);
    check("stop_mid_busy", 32'(busy), 32'd0);

    // START after 3 data bits: byte discarded, new read from pointer 2.
    bus_start();
    send_byte(8'hEE, I2C_ACK, "addr_w_ack");
    set_ptr(8'h02);
    for (int i = 0; i < 3; i++) bus_bit(1'b0, s);
    rd_bytes(1);
    bus_stop();

    // Reset while the address ACK is being driven low.
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(1'(8'hEE >> i), s);
    for (int i = 0; i < 40 && SDA_Out !== 1'b0; i++) wait_clk(1);
    check("ack_drive_before_reset", 32'(SDA_Out), 32'd0);
    Reset = 1'b1;
    wait_clk(1);
    check("reset_mid_sda", 32'(SDA_Out), 32'd1);
    check("reset_mid_busy", 32'(busy), 32'd0);
    check("reset_mid_addr", 32'(reg_addr), 32'd0);
    check("reset_mid_state", 32'(dbg_state), 32'(IDLE));
    Reset = 1'b0;
    model_ptr = 0;
    sda_m = 1'b1;
    wait_clk(6); SCL = 1'b1;
    wait_clk(10);

    // Randomised mix of writes, reads and foreign addresses.
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          bus_start();
          send_byte(8'hEE, I2C_ACK, "addr_w_ack");
          set_ptr(8'($urandom_range(0, 255)));
          n = $urandom_range(0, 3);
          for (int i = 0; i < n; i++) write_data(8'($urandom_range(0, 255)));
          bus_stop();
        end
        1: begin
          rd_bytes($urandom_range(1, 4));
          bus_stop();
        end
        2: begin
          bus_start();
          send_byte(8'hEE, I2C_ACK, "addr_w_ack");
          set_ptr(8'($urandom_range(0, 255)));
          rd_bytes($urandom_range(1, 3));
          bus_stop();
        end
        default: begin
          a = 7'($urandom_range(0, 127));
          if (a == 7'h77) a = 7'h10;
          bus_start();
          send_byte({a, 1'($urandom_range(0, 1))}, I2C_NACK, "foreign_addr_nack");
          bus_stop();
        end
      endcase
    end

    wait_clk(20);
    check("final_wr_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_rd_queue_empty", 32'(exp_rd_q.size()), 32'd0);
    check("final_idle", 32'(dbg_state), 32'(IDLE));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
